round_led_tracker: RTL and testbench
====================================

// Module: round_led_tracker
// PURPOSE
//  Per-round countdown tracker: lights NUM_LEDS LEDs at round start and extinguishes one per step; step rate is set by Difficulty.
//  Sits directly upstream of the access/game controller. Produces its LEDTimeOut input, a 1-cycle pulse meaning "round survived".
//  Consumes its NewGamePulse, PassedRoundPulse, GameOverPulse, EnableGameElements and Difficulty outputs.
//  Also keeps the rounds-passed count for the display path.
// PARAMETERS
//  BASE_TICKS  25_000_000  clock cycles per LED step at Difficulty=00 (0.5 s @ 50 MHz)
//  NUM_LEDS    10          LEDs in the countdown bar
// PORTS
//  Clk                 in   1         system clock; single clock domain
//  Reset               in   1         asynchronous, active-low reset
//  NewGamePulse        in   1         1-cycle pulse: start game from round 0
//  PassedRoundPulse    in   1         1-cycle pulse: controller accepted round pass; start next round
//  GameOverPulse       in   1         1-cycle pulse: crash/game end
//  EnableGameElements  in   1         high = countdown runs; low = countdown paused
//  Difficulty          in   2         00 easy .. 11 hardest
//  LEDs                out  NUM_LEDS  thermometer bar, LSB-aligned; bit i lit while >i steps remain
//  LEDTimeOut          out  1         1-cycle pulse when the last LED extinguishes
//  RoundCount          out  8         rounds passed this game; saturates at 255
//  Running             out  1         high while in RUN state
// BEHAVIOUR
//  Reset (Reset==0, async): state=IDLE; LEDs=0, LEDTimeOut=0, RoundCount=0, Running=0; prescaler and latched difficulty = 0.
//  All outputs are registered.
//  Step period P = max(1, BASE_TICKS >> DiffLatch).
//   DiffLatch samples Difficulty only on a round load (NewGamePulse, or PassedRoundPulse accepted in WAIT).
//   Changes to Difficulty mid-round are ignored.
//  States:
//   IDLE  -> RUN  on NewGamePulse: LEDs=all ones, RoundCount=0, prescaler=0.
//   RUN   : if EnableGameElements, prescaler++. When prescaler==P-1: prescaler=0, LEDs=LEDs>>1.
//           If EnableGameElements is low, prescaler and LEDs hold (pause; no loss of partial step).
//           The step that makes LEDs==0 also sets LEDTimeOut=1 in that same register update, then RUN -> WAIT.
//   WAIT  : LEDs=0, countdown stopped.
//           PassedRoundPulse -> RoundCount=sat(RoundCount+1), LEDs=all ones, prescaler=0, re-latch Difficulty, -> RUN.
//   OVER  : LEDs=0, RoundCount frozen for display, Running=0. NewGamePulse -> RUN as from IDLE.
//  GameOverPulse from any state -> OVER next cycle. Any in-flight step is discarded; LEDTimeOut is never raised that cycle.
//  Priority on simultaneous pulses: GameOverPulse > NewGamePulse > PassedRoundPulse.
//  NewGamePulse in RUN/WAIT restarts the game (RoundCount=0, full bar).
//  PassedRoundPulse outside WAIT is ignored.
//  LEDTimeOut is exactly one cycle wide. It cannot re-fire until a new round is loaded.
//  Latency: with enable held high, LEDTimeOut rises NUM_LEDS*P cycles after the load cycle.
//  Reset asserted mid-RUN: all outputs clear asynchronously; no pulse is emitted on release.
// STRUCTURE
//  Shared package/include tracker_defs: state encodings (IDLE=0, RUN=1, WAIT=2, OVER=3) and difficulty code localparams.
//  Sub-module step_prescaler(Clk, Reset, Enable, Clear, Period, Tick).
//   Counter width $clog2(BASE_TICKS).
//   Tick is high in the cycle count==Period-1 while Enable is high.
//  Top level holds the FSM, the LED shift register, RoundCount and DiffLatch.
// TESTING (bench: BASE_TICKS=8, NUM_LEDS=4)
//  1. Reset low mid-simulation -> LEDs=0000, LEDTimeOut=0, RoundCount=0, Running=0 immediately.
//  2. NewGamePulse, Diff=00, Enable=1 -> LEDs=1111.
//     Then 0111 after 8 cycles, 0000 after 32 cycles; LEDTimeOut high exactly 1 cycle at cycle 32.
//  3. Diff=11 at load -> P=1; timeout at cycle 4.
//     Diff=00->11 changed mid-round -> timeout still at cycle 32.
//  4. Enable low for 5 cycles at cycle 10 -> LEDTimeOut at cycle 37; LEDs unchanged during pause.
//  5. WAIT + PassedRoundPulse -> RoundCount 0->1, LEDs=1111.
//     Force RoundCount=255 then pass -> stays 255.
//     PassedRoundPulse in RUN -> no effect.
//  6. GameOverPulse and PassedRoundPulse in same cycle in WAIT -> OVER, RoundCount unchanged.
//     GameOverPulse in the final-step cycle -> no LEDTimeOut.

Source files
------------

// File: rtl/round_led_tracker_pkg.sv
// ---------------------------------------------------------------------------
// round_led_tracker_pkg: state encoding, difficulty codes and step-period helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package round_led_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam logic [1:0] C_DIFF_EASY    = 2'd0;
  localparam logic [1:0] C_DIFF_MEDIUM  = 2'd1;
  localparam logic [1:0] C_DIFF_HARD    = 2'd2;
  localparam logic [1:0] C_DIFF_HARDEST = 2'd3;

  // Each difficulty step halves the period; never below one cycle.
  function automatic int unsigned step_period(input int unsigned base, input logic [1:0] diff);
    int unsigned p;
    p = base >> diff;
    return (p == 0) ? 1 : p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/round_led_tracker_if.sv
// ---------------------------------------------------------------------------
// round_led_tracker_if: controller <-> tracker signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface round_led_tracker_if #(
  parameter int NUM_LEDS = 10
);
  logic                new_game_pulse;
  logic                passed_round_pulse;
  logic                game_over_pulse;
  logic                enable_game_elements;
  logic [1:0]          difficulty;
  logic [NUM_LEDS-1:0] leds;
  logic                led_time_out;
  logic [7:0]          round_count;
  logic                running;

  modport master (
    output new_game_pulse, passed_round_pulse, game_over_pulse,
           enable_game_elements, difficulty,
    input  leds, led_time_out, round_count, running
  );

  modport slave (
    input  new_game_pulse, passed_round_pulse, game_over_pulse,
           enable_game_elements, difficulty,
    output leds, led_time_out, round_count, running
  );
endinterface

`default_nettype wire

// File: rtl/round_led_tracker_step_prescaler.sv
// ---------------------------------------------------------------------------
// step_prescaler: pausable cycle counter emitting one tick per step period
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module step_prescaler #(
  parameter int unsigned BASE_TICKS = 25_000_000,
  localparam int CW = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1,
  localparam int PW = $clog2(BASE_TICKS + 1)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          enable,
  input  wire logic          clear,
  input  wire logic [PW-1:0] period,
  output logic               tick
);

  logic [CW-1:0] count;

  assign tick = enable && (PW'(count) == (period - PW'(1)));

  // Holding while disabled keeps any partial step across a pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/round_led_tracker.sv
// ---------------------------------------------------------------------------
// round_led_tracker: per-round LED countdown bar, timeout pulse and round count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module round_led_tracker
  import round_led_tracker_pkg::*;
#(
  parameter int unsigned BASE_TICKS = 25_000_000,
  parameter int          NUM_LEDS   = 10
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  round_led_tracker_if.slave bus
);

  localparam int PW = $clog2(BASE_TICKS + 1);

  state_t              state, state_n;
  logic [NUM_LEDS-1:0] leds_q, leds_n;
  logic [7:0]          rounds_q, rounds_n;
  logic [1:0]          diff_q, diff_n;
  logic                timeout_q, timeout_n;
  logic                running_q;
  logic                pre_clear;
  logic                pre_enable;
  logic                tick;
  logic [PW-1:0]       period;

  assign period     = PW'(step_period(BASE_TICKS, diff_q));
  assign pre_enable = (state == ST_RUN) && bus.enable_game_elements;

  step_prescaler #(
    .BASE_TICKS (BASE_TICKS)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (pre_enable),
    .clear  (pre_clear),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      leds_q    <= '0;
      rounds_q  <= '0;
      diff_q    <= '0;
      timeout_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_n;
      leds_q    <= leds_n;
      rounds_q  <= rounds_n;
      diff_q    <= diff_n;
      timeout_q <= timeout_n;
      running_q <= (state_n == ST_RUN);
    end
  end

  // Pulse priority: game over, then new game, then round pass.
  always_comb begin
    state_n   = state;
    leds_n    = leds_q;
    rounds_n  = rounds_q;
    diff_n    = diff_q;
    timeout_n = 1'b0;
    pre_clear = 1'b0;
    if (bus.game_over_pulse) begin
      state_n   = ST_OVER;
      leds_n    = '0;
      pre_clear = 1'b1;
    end else if (bus.new_game_pulse) begin
      state_n   = ST_RUN;
      leds_n    = '1;
      rounds_n  = '0;
      diff_n    = bus.difficulty;
      pre_clear = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (tick) begin
            leds_n = leds_q >> 1;
            if (leds_n == '0) begin
              timeout_n = 1'b1;
              state_n   = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.passed_round_pulse) begin
            rounds_n  = (rounds_q == 8'hFF) ? rounds_q : rounds_q + 8'd1;
            leds_n    = '1;
            diff_n    = bus.difficulty;
            pre_clear = 1'b1;
            state_n   = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.leds         = leds_q;
  assign bus.led_time_out = timeout_q;
  assign bus.round_count  = rounds_q;
  assign bus.running      = running_q;

endmodule

`default_nettype wire

// File: tb/tb_round_led_tracker.sv
// ---------------------------------------------------------------------------
// tb_round_led_tracker: directed and randomized checks against a work-remaining model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_round_led_tracker;

  localparam int BT = 8;
  localparam int NL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  round_led_tracker_if #(.NUM_LEDS(NL)) bus();

  round_led_tracker #(
    .BASE_TICKS (BT),
    .NUM_LEDS   (NL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a round is NL*P enabled cycles of work; lit LEDs = ceil(work left / P).
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_OVER = 3;
  int m_mode, m_rem, m_per, m_rounds;
  bit m_to;

  function automatic int per_of(input int d);
    int p;
    p = BT >> d;
    return (p < 1) ? 1 : p;
  endfunction

  function automatic logic [NL-1:0] exp_leds();
    int n;
    logic [31:0] bar;
    n   = (m_rem > 0) ? (m_rem + m_per - 1) / m_per : 0;
    bar = (32'd1 << n) - 32'd1;
    return bar[NL-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_rem = 0; m_per = 1; m_rounds = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (bus.game_over_pulse) begin
        m_mode = M_OVER; m_rem = 0;
      end else if (bus.new_game_pulse) begin
        m_mode = M_RUN; m_per = per_of(int'(bus.difficulty)); m_rem = NL * m_per; m_rounds = 0;
      end else if (m_mode == M_RUN) begin
        if (bus.enable_game_elements) begin
          m_rem--;
          if (m_rem == 0) begin m_to = 1; m_mode = M_WAIT; end
        end
      end else if (m_mode == M_WAIT && bus.passed_round_pulse) begin
        m_rounds = (m_rounds < 255) ? m_rounds + 1 : 255;
        m_per = per_of(int'(bus.difficulty)); m_rem = NL * m_per; m_mode = M_RUN;
      end
    end
  end

  always @(negedge clk) begin
    check("leds", 32'(bus.leds), 32'(exp_leds()));
    check("timeout", 32'(bus.led_time_out), 32'(m_to));
    check("rounds", 32'(bus.round_count), 32'(m_rounds));
    check("running", 32'(bus.running), 32'(m_mode == M_RUN));
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_new(input logic [1:0] d);
    @(negedge clk);
    bus.new_game_pulse = 1'b1; bus.difficulty = d;
    @(negedge clk);
    bus.new_game_pulse = 1'b0;
  endtask

  task automatic pulse_pass(input logic [1:0] d);
    @(negedge clk);
    bus.passed_round_pulse = 1'b1; bus.difficulty = d;
    @(negedge clk);
    bus.passed_round_pulse = 1'b0;
  endtask

  task automatic wait_to(input int already, output int n);
    n = already;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.led_time_out && n < 500);
    if (!bus.led_time_out) begin
      errors++;
      $display("FAIL timeout_wait: no LEDTimeOut within %0d cycles", n);
    end
  endtask

  initial begin
    int n;
    bus.new_game_pulse = 0; bus.passed_round_pulse = 0; bus.game_over_pulse = 0;
    bus.enable_game_elements = 1; bus.difficulty = 2'd0;
    cycles(3);
    check("reset_leds", 32'(bus.leds), 32'd0);
    check("reset_rounds", 32'(bus.round_count), 32'd0);
    check("reset_running", 32'(bus.running), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Easy round: full bar, first step after 8, timeout at 32.
    pulse_new(2'd0);
    check("t2_load_leds", 32'(bus.leds), 32'hF);
    cycles(8);
    check("t2_step_leds", 32'(bus.leds), 32'h7);
    wait_to(8, n);
    check("t2_timeout_cycle", 32'(n), 32'd32);
    check("t2_timeout_leds", 32'(bus.leds), 32'd0);
    @(negedge clk);
    check("t2_pulse_width", 32'(bus.led_time_out), 32'd0);

    pulse_new(2'd3);
    wait_to(0, n);
    check("t3_hardest_cycle", 32'(n), 32'd4);

    pulse_new(2'd0);
    cycles(5);
    bus.difficulty = 2'd3;
    wait_to(5, n);
    check("t3_midround_diff_cycle", 32'(n), 32'd32);
    bus.difficulty = 2'd0;

    pulse_new(2'd0);
    cycles(10);
    bus.enable_game_elements = 0;
    cycles(5);
    check("t4_paused_leds", 32'(bus.leds), 32'h7);
    bus.enable_game_elements = 1;
    wait_to(15, n);
    check("t4_pause_cycle", 32'(n), 32'd37);

    pulse_pass(2'd0);
    check("t5_pass_rounds", 32'(bus.round_count), 32'd1);
    check("t5_pass_leds", 32'(bus.leds), 32'hF);
    cycles(2);
    pulse_pass(2'd0);
    check("t5_pass_in_run", 32'(bus.round_count), 32'd1);
    for (int r = 0; r < 260; r++) begin
      wait_to(0, n);
      pulse_pass(2'd3);
    end
    check("t5_saturate", 32'(bus.round_count), 32'd255);

    wait_to(0, n);
    @(negedge clk);
    bus.game_over_pulse = 1'b1; bus.passed_round_pulse = 1'b1;
    @(negedge clk);
    bus.game_over_pulse = 1'b0; bus.passed_round_pulse = 1'b0;
    check("t6_over_running", 32'(bus.running), 32'd0);
    check("t6_over_rounds", 32'(bus.round_count), 32'd255);

    pulse_new(2'd0);
    cycles(31);
    bus.game_over_pulse = 1'b1;
    @(negedge clk);
    bus.game_over_pulse = 1'b0;
    check("t6_final_step_timeout", 32'(bus.led_time_out), 32'd0);
    check("t6_final_step_leds", 32'(bus.leds), 32'd0);
    cycles(2);
    check("t6_no_late_timeout", 32'(bus.led_time_out), 32'd0);

    // Asynchronous reset in the middle of a cycle during RUN.
    pulse_new(2'd1);
    cycles(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_leds", 32'(bus.leds), 32'd0);
    check("t1_async_running", 32'(bus.running), 32'd0);
    check("t1_async_rounds", 32'(bus.round_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);
    check("t1_release_timeout", 32'(bus.led_time_out), 32'd0);
    check("t1_release_running", 32'(bus.running), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.new_game_pulse       = ($urandom_range(63) == 0);
      bus.passed_round_pulse   = ($urandom_range(7) == 0);
      bus.game_over_pulse      = ($urandom_range(255) == 0);
      bus.enable_game_elements = ($urandom_range(9) < 8);
      bus.difficulty           = 2'($urandom_range(3));
    end
    @(negedge clk);
    bus.new_game_pulse = 0; bus.passed_round_pulse = 0; bus.game_over_pulse = 0;
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
